// File: rtl/mp_link_ctrl.sv
// Multiplayer link controller: ready handshake with the peer over the UART link,
// synchronised game start, and win/lose status driven by the received characters.
module mp_link_ctrl #(
  parameter int READY_PERIOD = 10000,
  parameter int START_HOLD   = 4,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       multiplayer,
  input  logic       local_ready,
  input  logic       local_over,
  input  logic       restart,
  input  logic [7:0] rx_char,
  input  logic       rx_valid,
  output logic       ready_req,
  output logic       lose_req,
  output logic       game_start,
  output logic       waiting,
  output logic       victory,
  output logic       defeat,
  output logic       link_timeout
);

  localparam int HOLD_CYCLES = START_HOLD * READY_PERIOD;
  localparam int CNT_MAX     = (WAIT_TIMEOUT > HOLD_CYCLES) ? WAIT_TIMEOUT : HOLD_CYCLES;
  localparam int CW          = $clog2(CNT_MAX + 1);
  localparam int PW          = $clog2(READY_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PEER, S_SYNC, S_PLAYING, S_WON, S_LOST
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [PW-1:0] per_q;
  logic [PW-1:0] per_d;
  logic          per_wrap;
  logic          rx_ready;
  logic          rx_lost;

  assign rx_ready = rx_valid && (rx_char == 8'h52);
  assign rx_lost  = rx_valid && (rx_char == 8'h4C);

  // cnt_d is "cycles spent in the state including this one"; per_wrap marks
  // that the next cycle starts a new ready period.
  assign cnt_d    = cnt_q + CW'(1);
  assign per_wrap = (per_q == PW'(READY_PERIOD - 1));
  assign per_d    = per_wrap ? '0 : per_q + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      per_q        <= '0;
      ready_req    <= 1'b0;
      lose_req     <= 1'b0;
      game_start   <= 1'b0;
      waiting      <= 1'b0;
      victory      <= 1'b0;
      defeat       <= 1'b0;
      link_timeout <= 1'b0;
    end else begin
      ready_req    <= 1'b0;
      lose_req     <= 1'b0;
      game_start   <= 1'b0;
      link_timeout <= 1'b0;
      if (!multiplayer) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        per_q   <= '0;
        waiting <= 1'b0;
        victory <= 1'b0;
        defeat  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            cnt_q <= '0;
            per_q <= '0;
            if (local_ready) begin
              state_q   <= S_WAIT_PEER;
              waiting   <= 1'b1;
              ready_req <= 1'b1;
            end
          end
          S_WAIT_PEER: begin
            if (!local_ready) begin
              state_q <= S_IDLE;
              waiting <= 1'b0;
              cnt_q   <= '0;
              per_q   <= '0;
            end else if (rx_ready) begin
              state_q   <= S_SYNC;
              cnt_q     <= '0;
              per_q     <= '0;
              ready_req <= 1'b1;
            end else if ((WAIT_TIMEOUT != 0) && (cnt_d == CW'(WAIT_TIMEOUT))) begin
              state_q      <= S_IDLE;
              waiting      <= 1'b0;
              link_timeout <= 1'b1;
              cnt_q        <= '0;
              per_q        <= '0;
            end else begin
              per_q     <= per_d;
              ready_req <= per_wrap;
              if (WAIT_TIMEOUT != 0) cnt_q <= cnt_d;
            end
          end
          S_SYNC: begin
            // Peer characters are deliberately ignored until the hold completes.
            if (cnt_d == CW'(HOLD_CYCLES)) begin
              state_q    <= S_PLAYING;
              waiting    <= 1'b0;
              game_start <= 1'b1;
              cnt_q      <= '0;
              per_q      <= '0;
            end else begin
              cnt_q     <= cnt_d;
              per_q     <= per_d;
              ready_req <= per_wrap;
            end
          end
          S_PLAYING: begin
            if (local_over) begin
              state_q  <= S_LOST;
              defeat   <= 1'b1;
              lose_req <= 1'b1;
            end else if (rx_lost) begin
              state_q <= S_WON;
              victory <= 1'b1;
            end
          end
          S_WON, S_LOST: begin
            if (restart) begin
              state_q <= S_IDLE;
              victory <= 1'b0;
              defeat  <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            waiting <= 1'b0;
            victory <= 1'b0;
            defeat  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mp_link_ctrl.sv
// Scoreboard bench for mp_link_ctrl: expected pulse events (kind + cycle) are queued
// with the stimulus and compared against pulses the monitor collects from the DUT.
module tb_mp_link_ctrl;

  localparam int K_RDY   = 0;
  localparam int K_LOSE  = 100000;
  localparam int K_START = 200000;
  localparam int K_TMO   = 300000;

  logic       clk = 1'b0;
  logic       rst;
  logic       multiplayer, local_ready, local_over, restart, rx_valid;
  logic [7:0] rx_char;
  logic       ready_req, lose_req, game_start, waiting, victory, defeat, link_timeout;
  logic [6:0] outs;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int base  = 0;
  int exp_q[$];
  int obs_q[$];

  assign outs = {ready_req, lose_req, game_start, waiting, victory, defeat, link_timeout};

  mp_link_ctrl #(.READY_PERIOD(4), .START_HOLD(2), .WAIT_TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .multiplayer(multiplayer), .local_ready(local_ready),
    .local_over(local_over), .restart(restart), .rx_char(rx_char), .rx_valid(rx_valid),
    .ready_req(ready_req), .lose_req(lose_req), .game_start(game_start), .waiting(waiting),
    .victory(victory), .defeat(defeat), .link_timeout(link_timeout)
  );

  always #5 clk = ~clk;

  // Pulse monitor: tags each observed pulse with its cycle relative to base.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (ready_req)    obs_q.push_back(K_RDY   + (cyc - base));
    if (lose_req)     obs_q.push_back(K_LOSE  + (cyc - base));
    if (game_start)   obs_q.push_back(K_START + (cyc - base));
    if (link_timeout) obs_q.push_back(K_TMO   + (cyc - base));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_scenario();
    exp_q.delete();
    obs_q.delete();
    base = cyc;
  endtask

  task automatic goto_playing();
    multiplayer = 1'b1;
    local_ready = 1'b1;
    tick(2);
    rx_char  = 8'h52;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(8);
  endtask

  task automatic test_reset();
    rst = 1'b1; multiplayer = 1'b0; local_ready = 1'b0; local_over = 1'b0;
    restart = 1'b0; rx_valid = 1'b0; rx_char = 8'h00;
    tick(3);
    n_cmp++;
    if (outs !== 7'b0) begin n_err++; $display("FAIL reset_outs: got %b want %b", outs, 7'b0); end
    rst = 1'b0;
    tick(2);
    n_cmp++;
    if (outs !== 7'b0) begin n_err++; $display("FAIL idle_outs: got %b want %b", outs, 7'b0); end
    $display("[tb] reset checked");
  endtask

  task automatic test_timeout();
    int e, o;
    start_scenario();
    multiplayer = 1'b1;
    local_ready = 1'b1;
    foreach (exp_q[i]) ;
    exp_q.push_back(K_RDY + 1);  exp_q.push_back(K_RDY + 5);  exp_q.push_back(K_RDY + 9);
    exp_q.push_back(K_RDY + 13); exp_q.push_back(K_RDY + 17); exp_q.push_back(K_TMO + 21);
    tick(1);
    n_cmp++;
    if (waiting !== 1'b1) begin n_err++; $display("FAIL to_waiting: got %b want 1", waiting); end
    tick(20);
    n_cmp++;
    if (waiting !== 1'b0) begin n_err++; $display("FAIL to_idle_waiting: got %b want 0", waiting); end
    local_ready = 1'b0;
    tick(2);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL to_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL to_pulse: got %0d want %0d", o, e); end
      else $display("[tb] timeout pulse %0d ok", o);
    end
  endtask

  task automatic test_sync();
    int e, o;
    start_scenario();
    multiplayer = 1'b1;
    local_ready = 1'b1;
    exp_q.push_back(K_RDY + 1); exp_q.push_back(K_RDY + 3);
    exp_q.push_back(K_RDY + 7); exp_q.push_back(K_START + 11);
    tick(2);
    rx_char = 8'h52; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    n_cmp++;
    if (waiting !== 1'b1) begin n_err++; $display("FAIL sync_waiting: got %b want 1", waiting); end
    tick(8);
    n_cmp++;
    if ({game_start, waiting} !== 2'b10) begin
      n_err++; $display("FAIL sync_start: got start/wait %b want 10", {game_start, waiting});
    end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL sync_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL sync_pulse: got %0d want %0d", o, e); end
      else $display("[tb] sync pulse %0d ok", o);
    end
  endtask

  task automatic test_lose();
    int e, o;
    start_scenario();
    exp_q.push_back(K_LOSE + 1);
    local_over = 1'b1;
    tick(1);
    n_cmp++;
    if (defeat !== 1'b1) begin n_err++; $display("FAIL lose_defeat: got %b want 1", defeat); end
    tick(9);
    local_over = 1'b0;
    n_cmp++;
    if ({victory, defeat} !== 2'b01) begin
      n_err++; $display("FAIL lose_hold: got vic/def %b want 01", {victory, defeat});
    end
    local_ready = 1'b0;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    n_cmp++;
    if (outs !== 7'b0) begin n_err++; $display("FAIL lose_restart: got %b want %b", outs, 7'b0); end
    tick(2);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL lose_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL lose_pulse: got %0d want %0d", o, e); end
      else $display("[tb] lose pulse %0d ok", o);
    end
  endtask

  task automatic test_win();
    int e, o;
    goto_playing();
    start_scenario();
    rx_char = 8'h4C; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    n_cmp++;
    if ({victory, defeat} !== 2'b10) begin
      n_err++; $display("FAIL win_status: got vic/def %b want 10", {victory, defeat});
    end
    tick(3);
    local_ready = 1'b0; restart = 1'b1;
    tick(1);
    restart = 1'b0;
    n_cmp++;
    if (victory !== 1'b0) begin n_err++; $display("FAIL win_restart: got %b want 0", victory); end
    n_cmp++;
    if (obs_q.size() !== 0) begin n_err++; $display("FAIL win_no_pulse: got %0d pulses want 0", obs_q.size()); end

    goto_playing();
    start_scenario();
    exp_q.push_back(K_LOSE + 1);
    rx_char = 8'h4C; rx_valid = 1'b1; local_over = 1'b1;
    tick(1);
    rx_valid = 1'b0; local_over = 1'b0;
    n_cmp++;
    if ({victory, defeat} !== 2'b01) begin
      n_err++; $display("FAIL tie_status: got vic/def %b want 01", {victory, defeat});
    end
    tick(2);
    local_ready = 1'b0; restart = 1'b1;
    tick(1);
    restart = 1'b0;
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL tie_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL tie_pulse: got %0d want %0d", o, e); end
      else $display("[tb] tie pulse %0d ok", o);
    end
  endtask

  task automatic test_ignore();
    int e, o;
    start_scenario();
    multiplayer = 1'b1;
    local_ready = 1'b1;
    exp_q.push_back(K_RDY + 1); exp_q.push_back(K_RDY + 5); exp_q.push_back(K_RDY + 7);
    tick(2);
    rx_char = 8'h41; rx_valid = 1'b1;
    tick(1);
    rx_char = 8'h4C;
    tick(1);
    rx_valid = 1'b0;
    n_cmp++;
    if ({waiting, victory} !== 2'b10) begin
      n_err++; $display("FAIL ign_wait: got wait/vic %b want 10", {waiting, victory});
    end
    tick(2);
    rx_char = 8'h52; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(2);
    multiplayer = 1'b0;
    tick(1);
    n_cmp++;
    if (waiting !== 1'b0) begin n_err++; $display("FAIL ign_mp_off: got %b want 0", waiting); end
    tick(12);
    local_ready = 1'b0;
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL ign_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL ign_pulse: got %0d want %0d", o, e); end
      else $display("[tb] ignore pulse %0d ok", o);
    end
  endtask

  task automatic test_async_reset();
    goto_playing();
    n_cmp++;
    if (game_start !== 1'b1) begin n_err++; $display("FAIL ar_start: got %b want 1", game_start); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 7'b0) begin n_err++; $display("FAIL ar_outs: got %b want %b", outs, 7'b0); end
    @(negedge clk);
    rst = 1'b0;
    start_scenario();
    tick(1);
    n_cmp++;
    if ({ready_req, waiting} !== 2'b11) begin
      n_err++; $display("FAIL ar_rejoin: got rdy/wait %b want 11", {ready_req, waiting});
    end
    multiplayer = 1'b0; local_ready = 1'b0;
    tick(2);
    $display("[tb] async reset checked");
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_sync();
    test_lose();
    test_win();
    test_ignore();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
